// File: rtl/jt1943_objbus_arb_if.sv
// Object-engine side of the shared work/object RAM bus between the video block and the
// CPU-side arbiter.
interface jt1943_objbus_arb_if;
    logic        bus_req;
    logic        bus_ack;
    logic        blcnten;
    logic [12:0] obj_AB;
    logic [7:0]  obj_DB;
    logic        OKOUT;

    modport master (
        output bus_req, blcnten, obj_AB,
        input  bus_ack, obj_DB, OKOUT
    );

    modport slave (
        input  bus_req, blcnten, obj_AB,
        output bus_ack, obj_DB, OKOUT
    );
endinterface

// File: rtl/jt1943_objbus_arb.sv
// CPU-side responder for the object engine bus: halts the Z80 via BUSRQ/BUSAK and lends it the shared RAM.
// Optional REQ timeout is enabled by defining JT1943_OBJARB_TIMEOUT_EN.
module jt1943_objbus_arb #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_cen,
    input  logic [12:0] cpu_AB,
    input  logic [7:0]  cpu_dout,
    input  logic        ram_cs,
    input  logic        wr_n,
    input  logic        okout_cs,
    output logic        busrq_n,
    input  logic        busak_n,
    jt1943_objbus_arb_if.slave obj,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic        okout_clr;
    logic        okout_set;
    logic        okout_q;
    logic        bus_ack_q;
    logic [7:0]  obj_db_q;
    logic [12:0] obj_hold;

`ifdef JT1943_OBJARB_TIMEOUT_EN
    localparam logic [9:0] TO_VAL = TIMEOUT[9:0];
    logic [9:0] to_cnt;
`endif

    assign okout_set   = okout_cs & ~wr_n & cpu_cen;
    assign obj.OKOUT   = okout_q;
    assign obj.bus_ack = bus_ack_q;
    assign obj.obj_DB  = obj_db_q;

    // NOTE: every output of a combinational block gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        okout_clr = 1'b0;
        case (state)
            IDLE:    if (obj.bus_req) state_nx = REQ;
            REQ: begin
                if (!busak_n)
                    state_nx = GRANT;
                else if (!obj.bus_req)
                    state_nx = RELEASE;
`ifdef JT1943_OBJARB_TIMEOUT_EN
                else if (to_cnt == TO_VAL) begin
                    state_nx  = RELEASE;
                    okout_clr = 1'b1;
                end
`endif
            end
            GRANT: begin
                if (!obj.bus_req) begin
                    state_nx  = RELEASE;
                    okout_clr = 1'b1;
                end
            end
            RELEASE: if (busak_n) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs are registered from the current state, so they trail the FSM by one clk.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busrq_n   <= 1'b1;
            bus_ack_q <= 1'b0;
            okout_q   <= 1'b0;
            obj_db_q  <= 8'h00;
            obj_hold  <= 13'h0000;
        end else begin
            state     <= state_nx;
            busrq_n   <= !(state == REQ || state == GRANT);
            bus_ack_q <= (state == GRANT);
            if (okout_set)
                okout_q <= 1'b1;
            else if (okout_clr)
                okout_q <= 1'b0;
            if (state == GRANT) begin
                obj_db_q <= ram_dout;
                if (obj.blcnten) obj_hold <= obj.obj_AB;
            end
        end
    end

`ifdef JT1943_OBJARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= 10'd0;
        else if (state != REQ)
            to_cnt <= 10'd0;
        else
            to_cnt <= to_cnt + 10'd1;
    end
`endif

    // RAM mux is combinational so obj_AB reaches obj_DB in two clks; reset forces it idle immediately.
    always_comb begin
        ram_addr = 13'h0000;
        ram_din  = 8'h00;
        ram_we   = 1'b0;
        if (rst_n) begin
            if (state == GRANT) begin
                ram_addr = obj.blcnten ? obj.obj_AB : obj_hold;
            end else begin
                ram_addr = cpu_AB;
                ram_din  = cpu_dout;
                ram_we   = ram_cs & ~wr_n & cpu_cen;
            end
        end
    end

endmodule

// File: tb/tb_jt1943_objbus_arb.sv
// Self-checking bench for jt1943_objbus_arb: table-driven CPU mux vectors plus handshake sequences.
// Define JT1943_OBJARB_TIMEOUT_EN to also exercise the REQ timeout with TIMEOUT=16.
module tb_jt1943_objbus_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_cen, ram_cs, wr_n, okout_cs;
    logic [12:0] cpu_AB;
    logic [7:0]  cpu_dout;
    logic        busrq_n;
    logic        busak_n;
    logic [12:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;

    logic [7:0]  mem [0:8191];

    int errors = 0;
    int checks = 0;

    jt1943_objbus_arb_if obj_bus ();

    jt1943_objbus_arb #(.TIMEOUT(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_cen  (cpu_cen),
        .cpu_AB   (cpu_AB),
        .cpu_dout (cpu_dout),
        .ram_cs   (ram_cs),
        .wr_n     (wr_n),
        .okout_cs (okout_cs),
        .busrq_n  (busrq_n),
        .busak_n  (busak_n),
        .obj      (obj_bus.slave),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // Shared RAM model, one clk read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic        cs;
        logic        wrn;
        logic        cen;
        logic [12:0] ab;
        logic [7:0]  dout;
        logic        exp_we;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_idle();
        ram_cs   = 1'b0;
        wr_n     = 1'b1;
        cpu_cen  = 1'b0;
        okout_cs = 1'b0;
    endtask

    task automatic okout_write();
        okout_cs = 1'b1;
        wr_n     = 1'b0;
        cpu_cen  = 1'b1;
        tick();
        cpu_idle();
    endtask

    task automatic wait_rq_low(input string name);
        for (int i = 0; i < 16; i++) begin
            if (!busrq_n) break;
            tick();
        end
        check(name, busrq_n, 1'b0);
    endtask

    task automatic wait_ack_high(input string name);
        for (int i = 0; i < 16; i++) begin
            if (obj_bus.bus_ack) break;
            tick();
        end
        check(name, obj_bus.bus_ack, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_ack, seen_rq;
        int low_cnt;

        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h1000] = 8'hA5;
        mem[13'h0010] = 8'h77;

        vecs[0] = '{cs: 1'b1, wrn: 1'b0, cen: 1'b1, ab: 13'h0020, dout: 8'h11, exp_we: 1'b1};
        vecs[1] = '{cs: 1'b1, wrn: 1'b0, cen: 1'b0, ab: 13'h0021, dout: 8'h22, exp_we: 1'b0};
        vecs[2] = '{cs: 1'b1, wrn: 1'b1, cen: 1'b1, ab: 13'h0022, dout: 8'h33, exp_we: 1'b0};
        vecs[3] = '{cs: 1'b0, wrn: 1'b0, cen: 1'b1, ab: 13'h0023, dout: 8'h44, exp_we: 1'b0};
        vecs[4] = '{cs: 1'b1, wrn: 1'b0, cen: 1'b1, ab: 13'h1FFF, dout: 8'hFF, exp_we: 1'b1};

        // Reset held with a pending request and an active CPU write
        rst_n            = 1'b0;
        obj_bus.bus_req  = 1'b1;
        obj_bus.blcnten  = 1'b0;
        obj_bus.obj_AB   = 13'h0000;
        busak_n          = 1'b1;
        ram_cs           = 1'b1;
        wr_n             = 1'b0;
        cpu_cen          = 1'b1;
        okout_cs         = 1'b1;
        cpu_AB           = 13'h1ABC;
        cpu_dout         = 8'h5A;
        repeat (3) tick();
        check("reset_busrq_n", busrq_n, 1'b1);
        check("reset_bus_ack", obj_bus.bus_ack, 1'b0);
        check("reset_okout", obj_bus.OKOUT, 1'b0);
        check("reset_obj_db", obj_bus.obj_DB, 8'h00);
        check("reset_ram_we", ram_we, 1'b0);
        check("reset_ram_addr", ram_addr, 13'h0000);

        cpu_idle();
        rst_n = 1'b1;
        tick();
        check("rq_after_1clk", busrq_n, 1'b1);
        tick();
        check("rq_after_2clk", busrq_n, 1'b0);
        obj_bus.bus_req = 1'b0;
        repeat (3) tick();
        check("rq_back_high", busrq_n, 1'b1);

        // CPU mux vectors in IDLE
        for (int i = 0; i < 5; i++) begin
            ram_cs   = vecs[i].cs;
            wr_n     = vecs[i].wrn;
            cpu_cen  = vecs[i].cen;
            cpu_AB   = vecs[i].ab;
            cpu_dout = vecs[i].dout;
            #1;
            check($sformatf("vec%0d_addr", i), ram_addr, vecs[i].ab);
            check($sformatf("vec%0d_din", i), ram_din, vecs[i].dout);
            check($sformatf("vec%0d_we", i), ram_we, vecs[i].exp_we);
            tick();
            cpu_idle();
        end

        // Full handshake with OKOUT held through REQ/GRANT
        okout_write();
        check("okout_set", obj_bus.OKOUT, 1'b1);
        obj_bus.bus_req = 1'b1;
        wait_rq_low("hs_busrq_low");
        repeat (5) tick();
        check("okout_in_req", obj_bus.OKOUT, 1'b1);
        check("no_ack_before_busak", obj_bus.bus_ack, 1'b0);
        busak_n = 1'b0;
        wait_ack_high("hs_bus_ack");
        check("okout_in_grant", obj_bus.OKOUT, 1'b1);

        // CPU write during GRANT is suppressed
        ram_cs   = 1'b1;
        wr_n     = 1'b0;
        cpu_cen  = 1'b1;
        cpu_AB   = 13'h0010;
        cpu_dout = 8'h3C;
        #1;
        check("grant_we_suppressed", ram_we, 1'b0);
        repeat (2) tick();
        cpu_idle();

        obj_bus.obj_AB  = 13'h1000;
        obj_bus.blcnten = 1'b1;
        tick();
        check("obj_db_1clk", obj_bus.obj_DB, 8'h00);
        tick();
        check("obj_db_2clk", obj_bus.obj_DB, 8'hA5);
        obj_bus.blcnten = 1'b0;
        obj_bus.obj_AB  = 13'h0ABC;
        #1;
        check("addr_hold", ram_addr, 13'h1000);
        check("ram10_unchanged", mem[13'h0010], 8'h77);

        // Release: ack drops, CPU regains the mux while BUSAK is still low
        obj_bus.bus_req = 1'b0;
        repeat (2) tick();
        check("rel_bus_ack", obj_bus.bus_ack, 1'b0);
        check("rel_busrq_n", busrq_n, 1'b1);
        check("okout_cleared", obj_bus.OKOUT, 1'b0);
        ram_cs   = 1'b1;
        wr_n     = 1'b0;
        cpu_cen  = 1'b1;
        cpu_AB   = 13'h0010;
        cpu_dout = 8'h3C;
        #1;
        check("rel_we", ram_we, 1'b1);
        check("rel_addr", ram_addr, 13'h0010);
        tick();
        cpu_idle();
        check("ram10_written", mem[13'h0010], 8'h3C);
        busak_n = 1'b1;
        repeat (2) tick();

        // OKOUT set coinciding with the GRANT->RELEASE clear: set wins
        okout_write();
        obj_bus.bus_req = 1'b1;
        wait_rq_low("sw_busrq_low");
        busak_n = 1'b0;
        wait_ack_high("sw_bus_ack");
        obj_bus.bus_req = 1'b0;
        okout_cs = 1'b1;
        wr_n     = 1'b0;
        cpu_cen  = 1'b1;
        tick();
        cpu_idle();
        check("okout_set_wins", obj_bus.OKOUT, 1'b1);
        tick();
        busak_n = 1'b1;
        repeat (2) tick();
        check("sw_bus_ack_low", obj_bus.bus_ack, 1'b0);
        check("sw_okout_held", obj_bus.OKOUT, 1'b1);

        // Aborted request: bus_req pulses 2 clk, BUSAK never answers
        seen_ack = 1'b0;
        seen_rq  = 1'b0;
        obj_bus.bus_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (obj_bus.bus_ack) seen_ack = 1'b1;
            if (!busrq_n) seen_rq = 1'b1;
            if (i == 1) obj_bus.bus_req = 1'b0;
        end
        check("abort_rq_seen", seen_rq, 1'b1);
        check("abort_no_ack", seen_ack, 1'b0);
        check("abort_busrq_n", busrq_n, 1'b1);
        check("abort_okout_kept", obj_bus.OKOUT, 1'b1);

`ifdef JT1943_OBJARB_TIMEOUT_EN
        // Timeout: busak_n stuck high, REQ gives up after 17 cycles
        seen_ack = 1'b0;
        obj_bus.bus_req = 1'b1;
        wait_rq_low("to_busrq_low");
        low_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (obj_bus.bus_ack) seen_ack = 1'b1;
            if (busrq_n) break;
            low_cnt++;
        end
        check("to_req_cycles", low_cnt, 17);
        check("to_okout_cleared", obj_bus.OKOUT, 1'b0);
        check("to_no_ack", seen_ack, 1'b0);
        obj_bus.bus_req = 1'b0;
        repeat (3) tick();
`else
        low_cnt = 0;
`endif

        // Reset asserted mid-GRANT forces idle outputs without a clock edge
        okout_write();
        obj_bus.bus_req = 1'b1;
        wait_rq_low("mr_busrq_low");
        busak_n = 1'b0;
        wait_ack_high("mr_bus_ack");
        obj_bus.obj_AB  = 13'h1000;
        obj_bus.blcnten = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_busrq_n", busrq_n, 1'b1);
        check("mr_bus_ack", obj_bus.bus_ack, 1'b0);
        check("mr_okout", obj_bus.OKOUT, 1'b0);
        check("mr_obj_db", obj_bus.obj_DB, 8'h00);
        check("mr_ram_addr", ram_addr, 13'h0000);
        obj_bus.bus_req = 1'b0;
        obj_bus.blcnten = 1'b0;
        busak_n = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
